// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - shortest-form immediate encoder: 16-bit constant to short, long or high/low pair words
module imm_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_value,
    input  logic [2:0]  in_rd,
    input  logic        in_allow13,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic        out_last,
    output logic [1:0]  out_kind,
    output logic [7:0]  wide_cnt
);
    localparam logic [2:0] OP9  = 3'b001;
    localparam logic [2:0] OP13 = 3'b010;
    localparam logic [2:0] OPHI = 3'b011;
    localparam logic [2:0] OPLO = 3'b100;

    typedef enum logic [1:0] {IDLE, ONE, HI, LO} state_t;

    state_t      state;
    logic [15:0] lo_word;
    logic        fits9;
    logic        fits13;
    logic        use_long;
    logic        is_pair;
    logic        accept;

    always_comb begin
        fits9    = (&in_value[15:8]) || !(|in_value[15:8]);
        fits13   = (&in_value[15:12]) || !(|in_value[15:12]);
        use_long = !fits9 && in_allow13 && fits13;
        is_pair  = !fits9 && !use_long;
    end

    // A new request may slip in during the cycle a final word drains, keeping the stream bubble-free.
    assign in_ready  = (state == IDLE) || ((state == ONE || state == LO) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            out_word <= 16'h0000;
            out_kind <= 2'd0;
            out_last <= 1'b0;
            lo_word  <= 16'h0000;
            wide_cnt <= 8'd0;
        end else begin
            if (accept) begin
                if (fits9) begin
                    out_word <= {OP9, in_rd, 1'b0, in_value[8:0]};
                    out_kind <= 2'd0;
                    out_last <= 1'b1;
                    state    <= ONE;
                end else if (use_long) begin
                    out_word <= {OP13, in_value[12:0]};
                    out_kind <= 2'd1;
                    out_last <= 1'b1;
                    state    <= ONE;
                end else begin
                    out_word <= {OPHI, in_rd, 2'b00, in_value[15:8]};
                    lo_word  <= {OPLO, in_rd, 2'b00, in_value[7:0]};
                    out_kind <= 2'd2;
                    out_last <= 1'b0;
                    state    <= HI;
                end
                if (is_pair && wide_cnt != 8'd255)
                    wide_cnt <= wide_cnt + 8'd1;
            end else if (out_ready) begin
                case (state)
                    HI: begin
                        out_word <= lo_word;
                        out_kind <= 2'd3;
                        out_last <= 1'b1;
                        state    <= LO;
                    end
                    ONE, LO: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed and randomized-backpressure bench for imm_encoder
module tb_imm_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_value = 16'h0000;
    logic [2:0]  in_rd = 3'd0;
    logic        in_allow13 = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_word;
    logic        out_last;
    logic [1:0]  out_kind;
    logic [7:0]  wide_cnt;

    int checks = 0;
    int failures = 0;

    imm_encoder dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_value(in_value), .in_rd(in_rd), .in_allow13(in_allow13),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_last(out_last), .out_kind(out_kind), .wide_cnt(wide_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [15:0] v, input logic [2:0] rd, input logic al);
        in_valid = 1'b1; in_value = v; in_rd = rd; in_allow13 = al;
        step();
        in_valid = 1'b0;
    endtask

    function automatic logic [1:0] exp_kind(input logic [15:0] v, input logic al);
        if (v[15:8] == 8'h00 || v[15:8] == 8'hFF) return 2'd0;
        if (al && (v[15:12] == 4'h0 || v[15:12] == 4'hF)) return 2'd1;
        return 2'd2;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_word !== 16'h0000) begin failures++; $display("FAIL reset_word got=%h exp=0000", out_word); end
        checks++; if ({out_kind, out_last} !== 3'b000) begin failures++; $display("FAIL reset_kind_last got=%b exp=000", {out_kind, out_last}); end
        checks++; if (wide_cnt !== 8'd0) begin failures++; $display("FAIL reset_wide got=%0d exp=0", wide_cnt); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_short();
        out_ready = 1'b0;
        req(16'h00FF, 3'd5, 1'b0);
        checks++; if ({out_valid, out_word, out_kind, out_last} !== {1'b1, 16'h34FF, 2'd0, 1'b1})
            begin failures++; $display("FAIL short_00ff got=%b/%h/%0d/%b exp=1/34ff/0/1", out_valid, out_word, out_kind, out_last); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL short_drain got=%b exp=0", out_valid); end
        req(16'hFF00, 3'd0, 1'b0);
        checks++; if ({out_word, out_kind, out_last} !== {16'h2100, 2'd0, 1'b1})
            begin failures++; $display("FAIL short_ff00 got=%h/%0d/%b exp=2100/0/1", out_word, out_kind, out_last); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
    endtask

    task automatic test_pair();
        checks++; if (wide_cnt !== 8'd0) begin failures++; $display("FAIL pair_wide_before got=%0d exp=0", wide_cnt); end
        req(16'h1234, 3'd2, 1'b1);
        checks++; if ({out_word, out_kind, out_last} !== {16'h6812, 2'd2, 1'b0})
            begin failures++; $display("FAIL pair_hi got=%h/%0d/%b exp=6812/2/0", out_word, out_kind, out_last); end
        checks++; if (wide_cnt !== 8'd1) begin failures++; $display("FAIL pair_wide_after got=%0d exp=1", wide_cnt); end
        out_ready = 1'b1; step();
        checks++; if ({out_valid, out_word, out_kind, out_last} !== {1'b1, 16'h8834, 2'd3, 1'b1})
            begin failures++; $display("FAIL pair_lo got=%h/%0d/%b exp=8834/3/1", out_word, out_kind, out_last); end
        step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL pair_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_long();
        req(16'h0100, 3'd0, 1'b1);
        checks++; if ({out_word, out_kind, out_last} !== {16'h4100, 2'd1, 1'b1})
            begin failures++; $display("FAIL long_0100 got=%h/%0d/%b exp=4100/1/1", out_word, out_kind, out_last); end
        out_ready = 1'b1; step(); out_ready = 1'b0;
        req(16'h0100, 3'd0, 1'b0);
        checks++; if ({out_word, out_kind} !== {16'h6001, 2'd2})
            begin failures++; $display("FAIL nolong_hi got=%h/%0d exp=6001/2", out_word, out_kind); end
        out_ready = 1'b1; step();
        checks++; if ({out_word, out_kind} !== {16'h8000, 2'd3})
            begin failures++; $display("FAIL nolong_lo got=%h/%0d exp=8000/3", out_word, out_kind); end
        step(); out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        req(16'h8000, 3'd7, 1'b1);
        in_valid = 1'b1; in_value = 16'h0001; in_rd = 3'd1;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({in_ready, out_word, out_kind} !== {1'b0, 16'h7C80, 2'd2})
                begin failures++; $display("FAIL bp_hold%0d got=%b/%h/%0d exp=0/7c80/2", i, in_ready, out_word, out_kind); end
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; step();
        checks++; if ({out_valid, out_word, out_kind, out_last} !== {1'b1, 16'h9C00, 2'd3, 1'b1})
            begin failures++; $display("FAIL bp_release got=%b/%h/%0d/%b exp=1/9c00/3/1", out_valid, out_word, out_kind, out_last); end
        step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = 16'(i * 37 - 100);
            in_valid = 1'b1; in_value = v; in_rd = 3'(i); in_allow13 = 1'b0;
            step();
            checks++; if ({out_valid, out_word} !== {1'b1, 3'b001, 3'(i), 1'b0, v[8:0]})
                begin failures++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, out_valid, out_word, {3'b001, 3'(i), 1'b0, v[8:0]}); end
        end
        in_valid = 1'b0; step(); out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_random_ready();
        logic [15:0] vals [16] = '{16'h0000, 16'h007F, 16'hFF80, 16'h00FF, 16'hFF00, 16'h0100, 16'hF000, 16'h0FFF,
                                   16'h1000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h1234, 16'hEDCB, 16'hF0FF, 16'h0FF0};
        logic [15:0] exp_q [$];
        logic [1:0]  kind_q [$];
        logic [15:0] hi, w, dec, ev;
        logic [1:0]  k, ek;
        logic        acc, take;
        int idx = 0;
        int cyc = 0;
        while ((idx < 16 || exp_q.size() > 0) && cyc < 1000) begin
            cyc++;
            in_valid = (idx < 16);
            if (idx < 16) begin
                in_value = vals[idx]; in_rd = 3'(idx); in_allow13 = idx[0];
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            acc = in_valid && in_ready;
            take = out_valid && out_ready;
            w = out_word; k = out_kind;
            step();
            if (acc) begin
                exp_q.push_back(vals[idx]);
                kind_q.push_back(exp_kind(vals[idx], idx[0]));
                idx++;
            end
            if (take) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++; $display("FAIL rand_extra word=%h", w);
                end else if (k == 2'd2) begin
                    hi = w;
                    checks++; if (kind_q[0] !== 2'd2) begin failures++; $display("FAIL rand_kind got=2 exp=%0d", kind_q[0]); end
                end else begin
                    ev = exp_q.pop_front(); ek = kind_q.pop_front();
                    if (k == 2'd3) dec = {hi[7:0], w[7:0]};
                    else if (k == 2'd1) dec = {{3{w[12]}}, w[12:0]};
                    else dec = {{7{w[8]}}, w[8:0]};
                    checks++; if (dec !== ev) begin failures++; $display("FAIL rand_value got=%h exp=%h", dec, ev); end
                    if (k != 2'd3) begin
                        checks++; if (k !== ek) begin failures++; $display("FAIL rand_kind got=%0d exp=%0d", k, ek); end
                    end
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (idx != 16 || exp_q.size() != 0)
            begin failures++; $display("FAIL rand_timeout got=%0d/%0d exp=16/0", idx, exp_q.size()); end
    endtask

    task automatic test_reset_mid_and_saturate();
        req(16'h4000, 3'd1, 1'b0);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        checks++; if (out_kind !== 2'd3) begin failures++; $display("FAIL mid_in_lo got=%0d exp=3", out_kind); end
        rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_async got=%b exp=0", out_valid); end
        step(); rst = 1'b0; #1;
        checks++; if ({out_valid, out_word, out_kind, out_last, wide_cnt} !== 28'h0)
            begin failures++; $display("FAIL mid_reset got=%b/%h/%0d/%b/%0d exp=0/0000/0/0/0", out_valid, out_word, out_kind, out_last, wide_cnt); end
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1; in_value = 16'h4000; in_allow13 = 1'b0;
            step();
            in_valid = 1'b0;
            step();
            if (i == 253) begin
                checks++; if (wide_cnt !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", wide_cnt); end
            end
        end
        step(); out_ready = 1'b0;
        checks++; if (wide_cnt !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", wide_cnt); end
    endtask

    initial begin
        test_reset();
        test_short();
        test_pair();
        test_long();
        test_backpressure();
        test_back_to_back();
        test_random_ready();
        test_reset_mid_and_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
